// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad decoder.
// Key map index is {column, row}, rows numbered top to bottom.
package keypad_pkg;

    localparam int SCAN_TICKS_DEFAULT     = 100000;
    localparam int DEBOUNCE_SCANS_DEFAULT = 4;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } scan_cls_t;

    // Entry 0 is col0/row0; leftmost literal is entry 15 (col3/row3).
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,
        4'hE, 4'h9, 4'h6, 4'h3,
        4'hF, 4'h8, 4'h5, 4'h2,
        4'h0, 4'h7, 4'h4, 4'h1
    };

    // Position of the lowest asserted row; only meaningful with exactly one bit set.
    function automatic logic [1:0] row_pos(input logic [3:0] low_rows);
        logic [1:0] pos;
        pos = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (low_rows[r]) pos = 2'(r);
        end
        return pos;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scan timing: one-cold active-low column drive, rotating every SCAN_TICKS
// cycles, with a sample strobe on the last cycle of each column period.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = SCAN_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       sample,
    output logic       scan_done
);

    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

    logic [TICK_W-1:0] tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            col_idx <= 2'd0;
        end else if (tick == TICK_LAST) begin
            tick    <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign sample    = (tick == TICK_LAST);
    assign scan_done = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 keypad decoder: per-scan classification, debounce FSM and registered
// key outputs. Column timing lives in keypad_col_scanner.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = SCAN_TICKS_DEFAULT,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] number_input,
    output logic       digit_changed,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic [1:0] col_idx;
    logic       sample;
    logic       scan_done;

    keypad_col_scanner #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .col_idx  (col_idx),
        .sample   (sample),
        .scan_done(scan_done)
    );

    logic [3:0] low_rows;
    logic [2:0] col_hits;
    logic [1:0] base_hits;
    logic [2:0] scan_sum;
    logic [1:0] next_hits;
    logic [3:0] next_code;
    logic [1:0] acc_hits;
    logic [3:0] acc_code;
    scan_cls_t  next_cls;

    // Hit count saturates at 2; column 0 starts a fresh scan.
    always_comb begin
        low_rows  = ~row;
        col_hits  = 3'(low_rows[0]) + 3'(low_rows[1]) + 3'(low_rows[2]) + 3'(low_rows[3]);
        base_hits = (col_idx == 2'd0) ? 2'd0 : acc_hits;
        scan_sum  = 3'(base_hits) + col_hits;
        next_hits = (scan_sum > 3'd2) ? 2'd2 : scan_sum[1:0];
        next_code = acc_code;
        if (col_hits == 3'd1) next_code = KEY_MAP[{col_idx, row_pos(low_rows)}];
        case (next_hits)
            2'd0:    next_cls = CLS_NONE;
            2'd1:    next_cls = CLS_SINGLE;
            default: next_cls = CLS_MULTI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sample) begin
            acc_hits <= next_hits;
            acc_code <= next_code;
        end
    end

    // p1: scan result registered at the end of column 3
    scan_cls_t  scan_cls_p1;
    logic [3:0] scan_code_p1;
    logic       vld_p1;

    always_ff @(posedge clk) begin
        if (scan_done) begin
            scan_cls_p1  <= next_cls;
            scan_code_p1 <= next_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= scan_done;
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand;
    logic             is_single;
    logic             is_none;
    logic             accept;
    logic             drop;

    always_comb begin
        cnt_inc   = cnt + 1'b1;
        is_single = (scan_cls_p1 == CLS_SINGLE);
        is_none   = (scan_cls_p1 == CLS_NONE);
        accept    = vld_p1 && is_single &&
                    ((state == SCAN && DEBOUNCE_SCANS == 1) ||
                     (state == CONFIRM && scan_code_p1 == cand && cnt_inc == CNT_DONE));
        drop      = vld_p1 && is_none &&
                    ((state == HELD && DEBOUNCE_SCANS == 1) ||
                     (state == RELEASE && cnt_inc == CNT_DONE));
    end

    // p2: debounce state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN;
            cnt           <= '0;
            number_input  <= 4'd0;
            key_code      <= 4'd0;
            digit_changed <= 1'b0;
            key_pressed   <= 1'b0;
        end else begin
            if (vld_p1) begin
                case (state)
                    SCAN: begin
                        if (is_single) begin
                            cand  <= scan_code_p1;
                            cnt   <= CNT_W'(1);
                            state <= (DEBOUNCE_SCANS == 1) ? HELD : CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (!is_single) begin
                            state <= SCAN;
                        end else if (scan_code_p1 != cand) begin
                            cand <= scan_code_p1;
                            cnt  <= CNT_W'(1);
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) state <= HELD;
                        end
                    end
                    HELD: begin
                        if (is_none) begin
                            cnt   <= CNT_W'(1);
                            state <= (DEBOUNCE_SCANS == 1) ? SCAN : RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!is_none) begin
                            state <= HELD;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) state <= SCAN;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
            if (accept) begin
                key_code    <= scan_code_p1;
                key_pressed <= 1'b1;
                if (scan_code_p1 <= 4'd9) begin
                    number_input  <= scan_code_p1;
                    digit_changed <= 1'b1;
                end
            end
            if (drop) begin
                key_pressed   <= 1'b0;
                digit_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder with 4-cycle columns and 2-scan debounce:
// a keypad model drives rows, a reference model predicts outputs per scan.
module tb_keypad_decoder;

    localparam int ST       = 4;
    localparam int DEB      = 2;
    localparam int SCAN_CYC = 4 * ST;

    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K4 = 16'h0002;
    localparam logic [15:0] K7 = 16'h0004;
    localparam logic [15:0] K2 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K8 = 16'h0040;
    localparam logic [15:0] KF = 16'h0080;
    localparam logic [15:0] K3 = 16'h0100;
    localparam logic [15:0] K9 = 16'h0400;
    localparam logic [15:0] KA = 16'h1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] number_input;
    logic       digit_changed;
    logic [3:0] key_code;
    logic       key_pressed;
    logic [15:0] pressed = 16'h0000;

    always #5 clk = ~clk;

    keypad_decoder #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .number_input (number_input),
        .digit_changed(digit_changed),
        .key_code     (key_code),
        .key_pressed  (key_pressed)
    );

    // Pressed keys short their row to whichever column is driven low.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (!col[k]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[k*4+r]) row[r] = 1'b0;
                end
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int since_rst   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    typedef struct {
        int         due;
        int         id;
        logic       kp;
        logic       dc;
        logic [3:0] code;
        logic [3:0] num;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [3:0] ce;

    always @(negedge clk) begin
        if (cyc > 0) begin
            ce = ~(4'b0001 << ((since_rst / ST) % 4));
            chk("col", 32'(col), 32'(ce));
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("scan%0d key_pressed", e.id), 32'(key_pressed), 32'(e.kp));
            chk($sformatf("scan%0d digit_changed", e.id), 32'(digit_changed), 32'(e.dc));
            chk($sformatf("scan%0d key_code", e.id), 32'(key_code), 32'(e.code));
            chk($sformatf("scan%0d number_input", e.id), 32'(number_input), 32'(e.num));
        end
    end

    int kmap[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    int         m_state = 0;
    int         m_cnt   = 0;
    int         m_cand  = 0;
    logic       m_kp    = 1'b0;
    logic       m_dc    = 1'b0;
    logic [3:0] m_code  = 4'd0;
    logic [3:0] m_num   = 4'd0;
    int         scan_id = 0;

    task automatic m_accept(input int code);
        m_state = 2;
        m_kp    = 1'b1;
        m_code  = 4'(code);
        if (code <= 9) begin
            m_num = 4'(code);
            m_dc  = 1'b1;
        end
    endtask

    task automatic m_release();
        m_state = 0;
        m_kp    = 1'b0;
        m_dc    = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] mask);
        int n;
        int code;
        n    = 0;
        code = 0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                n++;
                code = kmap[i];
            end
        end
        if (m_state == 0) begin
            if (n == 1) begin
                m_cand = code;
                m_cnt  = 1;
                if (m_cnt >= DEB) m_accept(code);
                else              m_state = 1;
            end
        end else if (m_state == 1) begin
            if (n != 1) m_state = 0;
            else if (code != m_cand) begin
                m_cand = code;
                m_cnt  = 1;
            end else begin
                m_cnt++;
                if (m_cnt >= DEB) m_accept(code);
            end
        end else if (m_state == 2) begin
            if (n == 0) begin
                m_cnt = 1;
                if (m_cnt >= DEB) m_release();
                else              m_state = 3;
            end
        end else begin
            if (n != 0) m_state = 2;
            else begin
                m_cnt++;
                if (m_cnt >= DEB) m_release();
            end
        end
    endtask

    // Called just after a negedge at the start of a full scan.
    task automatic run_scan(input logic [15:0] mask);
        exp_t o;
        exp_t n;
        o.due = cyc + SCAN_CYC;
        o.id  = scan_id;
        o.kp  = m_kp;
        o.dc  = m_dc;
        o.code = m_code;
        o.num  = m_num;
        model_scan(mask);
        n.due = cyc + SCAN_CYC + 1;
        n.id  = scan_id;
        n.kp  = m_kp;
        n.dc  = m_dc;
        n.code = m_code;
        n.num  = m_num;
        sb.push_back(o);
        sb.push_back(n);
        scan_id++;
        pressed = mask;
        repeat (SCAN_CYC) @(negedge clk);
    endtask

    task automatic run_scans(input logic [15:0] mask, input int count);
        for (int i = 0; i < count; i++) run_scan(mask);
    endtask

    exp_t r;

    initial begin
        rst     = 1'b1;
        pressed = K_NONE;
        repeat (3) @(negedge clk);
        chk("rst key_pressed", 32'(key_pressed), 32'd0);
        chk("rst digit_changed", 32'(digit_changed), 32'd0);
        chk("rst key_code", 32'(key_code), 32'd0);
        chk("rst number_input", 32'(number_input), 32'd0);
        chk("rst col", 32'(col), 32'hE);
        rst = 1'b0;

        // Digit 5: accept after two scans, release after two empty scans
        run_scans(K5, 3);
        run_scans(K_NONE, 3);
        // Non-digit F keeps number_input at 5
        run_scans(KF, 3);
        run_scans(K_NONE, 2);
        // 7 for one scan then 8 for two: only 8 accepted
        run_scan(K7);
        run_scans(K8, 2);
        run_scans(K_NONE, 2);
        // Multi-key in different and same columns
        run_scans(K1 | K2, 3);
        run_scans(K1 | K4, 2);
        // 3 held, second key added, bounce gap
        run_scans(K3, 2);
        run_scans(K3 | K1, 2);
        run_scan(K3);
        run_scan(K_NONE);
        run_scans(K3, 2);
        run_scans(K_NONE, 2);
        // Letter key A
        run_scans(KA, 2);
        run_scans(K_NONE, 2);
        // Reset while 9 is held
        run_scans(K9, 3);
        @(negedge clk);
        rst     = 1'b1;
        m_state = 0;
        m_cnt   = 0;
        m_kp    = 1'b0;
        m_dc    = 1'b0;
        m_code  = 4'd0;
        m_num   = 4'd0;
        r.due   = cyc + 1;
        r.id    = scan_id;
        r.kp    = 1'b0;
        r.dc    = 1'b0;
        r.code  = 4'd0;
        r.num   = 4'd0;
        sb.push_back(r);
        scan_id++;
        @(negedge clk);
        chk("held-rst col", 32'(col), 32'hE);
        rst = 1'b0;
        run_scans(K9, 3);
        run_scans(K_NONE, 2);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
